// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM state encoding, RV32I funct3 size/sign codes and the
// byte-enable helper used by the store path.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // size is funct3[1:0]; 2'b1x is a full word. Halfword lanes come from
  // off[1] alone, so a misaligned halfword truncates to its aligned half.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   byte_en = 4'b0001 << off;
      2'b01:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the addressed byte/half from a memory word
// and sign- or zero-extends it. Purely combinational, zero latency.
// Ports: word (raw memory word), offset (addr[1:0]), funct3 (size/sign), data (extended result).
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
  end

  // Halfword lane uses offset[1] only: misaligned halves truncate.
  assign h = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: turns an effective address + funct3 into a single-outstanding
// req/gnt/rvalid memory access. Latency: store resp 2 cycles after accept, load 3 (min).
// Backpressure: req_ready only in IDLE; Stall held through REQ/WAIT/DONE; waits on mem_gnt/mem_rvalid.
// Ports: clk, rst_n; execute side req_valid/req_ready, MemRead, MemWrite, Funct3,
// ALUResult, WriteData; writeback side Stall, resp_valid, ReadData; memory side
// mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_gnt, mem_rvalid, mem_rdata.
// Optional: LSU_MISALIGN_TRAP_EN adds output misaligned and completes misaligned
// accesses immediately without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_be,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  misaligned,
`endif
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic                  ld_q;
  logic                  accept;
  logic                  trap;
  logic [DATA_WIDTH-1:0] wdata_lanes;
  logic [DATA_WIDTH-1:0] ext_data;

  assign accept = req_valid && req_ready && (MemRead || MemWrite);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                (Funct3[1] && (ALUResult[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Replicate store data across lanes; byte enables pick the live lane.
  always_comb begin
    case (Funct3[1:0])
      2'b00:   wdata_lanes = {4{WriteData[7:0]}};
      2'b01:   wdata_lanes = {2{WriteData[15:0]}};
      default: wdata_lanes = WriteData;
    endcase
  end

  load_extend u_ext (
    .word   (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      Stall      <= 1'b0;
      resp_valid <= 1'b0;
      ReadData   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      ld_q       <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            off_q     <= ALUResult[1:0];
            f3_q      <= Funct3;
            ld_q      <= MemRead;          // read wins when both are set
            req_ready <= 1'b0;
            Stall     <= 1'b1;
            if (trap) begin
              state      <= DONE;
              resp_valid <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
              misaligned <= 1'b1;
`endif
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= !MemRead;
              mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
              mem_be    <= MemRead ? 4'b1111 : byte_en(Funct3[1:0], ALUResult[1:0]);
              mem_wdata <= wdata_lanes;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if (ld_q) begin
              state <= WAIT;
            end else begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            ReadData   <= ext_data;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin  // DONE
          resp_valid <= 1'b0;
          Stall      <= 1'b0;
          req_ready  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          misaligned <= 1'b0;
`endif
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses checked cycle by cycle against a transaction-level model.
// Works with and without LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ALUResult = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        Stall;
  logic        resp_valid;
  logic [31:0] ReadData;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misaligned;
`endif
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'h0;

  // Request presented while the previous one is still in flight.
  bit          hold_en = 1'b0;
  bit          h_rd, h_wr;
  logic [2:0]  h_f3;
  logic [31:0] h_addr, h_wd;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .Stall      (Stall),
    .resp_valid (resp_valid),
    .ReadData   (ReadData),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
`ifdef LSU_MISALIGN_TRAP_EN
    .misaligned (misaligned),
`endif
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sz(input logic [2:0] f3);
    return int'(f3 & 3'b011);   // 0 byte, 1 half, 2/3 word
  endfunction

  function automatic logic [3:0] m_be(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    if (ld || sz(f3) >= 2) return 4'hF;
    if (sz(f3) == 0) return 4'(1 << off);
    return (off >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (sz(f3) == 0) return (d % 256) * 32'h01010101;
    if (sz(f3) == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int off = int'(a % 4);
    int v;
    case (f3)
      3'd0, 3'd4: begin
        v = int'((w >> (8 * off)) % 256);
        if (f3 == 3'd0 && v > 127) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = int'((w >> (16 * (off / 2))) % 65536);
        if (f3 == 3'd1 && v > 32767) v = v - 65536;
      end
      default: return w;
    endcase
    return 32'(v);
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    if (sz(f3) == 1) return (a % 2) != 0;
    if (sz(f3) >= 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  // Caller is at a negedge with the DUT idle. Returns at the negedge of the
  // resp_valid cycle. gd = REQ cycles before grant, rvd = cycles grant->rvalid.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gd, input int rvd, input logic [31:0] rdat);
    bit ld = rd;
    check("idle_ready", {31'h0, req_ready}, 32'd1);
    check("idle_stall", {31'h0, Stall}, 32'd0);
    check("idle_resp", {31'h0, resp_valid}, 32'd0);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
    ALUResult = addr; WriteData = wd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    if (hold_en) begin
      MemRead = h_rd; MemWrite = h_wr; Funct3 = h_f3; ALUResult = h_addr; WriteData = h_wd;
    end else begin
      req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (m_mis(f3, addr)) begin
      check("trap_resp", {31'h0, resp_valid}, 32'd1);
      check("trap_flag", {31'h0, misaligned}, 32'd1);
      check("trap_noreq", {31'h0, mem_req}, 32'd0);
      check("trap_rdata", ReadData, last_rd);
      return;
    end
    check("mis_flag", {31'h0, misaligned}, 32'd0);
`endif
    for (int i = 0; i <= gd; i++) begin
      if (i > 0) @(negedge clk);
      check("req_mem_req", {31'h0, mem_req}, 32'd1);
      check("req_we", {31'h0, mem_we}, {31'h0, !ld});
      check("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("req_be", {28'h0, mem_be}, {28'h0, m_be(ld, f3, addr)});
      if (!ld) check("req_wdata", mem_wdata, m_wdata(f3, wd));
      check("req_stall", {31'h0, Stall}, 32'd1);
      check("req_ready_lo", {31'h0, req_ready}, 32'd0);
      check("req_noresp", {31'h0, resp_valid}, 32'd0);
      mem_gnt = (i == gd);
    end
    if (ld) begin
      for (int i = 1; i <= rvd; i++) begin
        @(negedge clk);
        mem_gnt = 1'b0;
        check("wait_noreq", {31'h0, mem_req}, 32'd0);
        check("wait_noresp", {31'h0, resp_valid}, 32'd0);
        check("wait_stall", {31'h0, Stall}, 32'd1);
        check("wait_ready_lo", {31'h0, req_ready}, 32'd0);
        mem_rvalid = (i == rvd);
        mem_rdata = (i == rvd) ? rdat : $urandom;
      end
      last_rd = m_load(f3, addr, rdat);
    end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("done_resp", {31'h0, resp_valid}, 32'd1);
    check("done_stall", {31'h0, Stall}, 32'd1);
    check("done_ready_lo", {31'h0, req_ready}, 32'd0);
    check("done_rdata", ReadData, last_rd);
    check("done_noreq", {31'h0, mem_req}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_stall", {31'h0, Stall}, 32'd0);
    check("rst_resp", {31'h0, resp_valid}, 32'd0);
    check("rst_mem_req", {31'h0, mem_req}, 32'd0);
    check("rst_rdata", ReadData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store byte at 0x103: lane 3, replicated data.
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 0, 1, 32'h0);
    @(negedge clk);
    // Signed/unsigned byte and signed half from 0x80FF7F01.
    do_access(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 0, 1, 32'h80FF_7F01);
    check("lb_val", ReadData, 32'hFFFF_FFFF);
    @(negedge clk);
    do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 1, 32'h80FF_7F01);
    check("lbu_val", ReadData, 32'h0000_0080);
    @(negedge clk);
    do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 1, 32'h80FF_7F01);
    check("lh_val", ReadData, 32'hFFFF_80FF);
    @(negedge clk);
    // Grant held off for 3 cycles.
    do_access(1'b0, 1'b1, 3'b001, 32'h22, 32'hCAFE_1234, 3, 1, 32'h0);
    @(negedge clk);
    // Delayed LW with a second request held the whole time.
    hold_en = 1'b1; h_rd = 1'b0; h_wr = 1'b1; h_f3 = 3'b010; h_addr = 32'h40; h_wd = 32'h5555_AAAA;
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 4, 32'hDEAD_BEEF);
    check("lw_val", ReadData, 32'hDEAD_BEEF);
    hold_en = 1'b0;
    @(negedge clk);
    do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h5555_AAAA, 0, 1, 32'h0);
    @(negedge clk);
    // Both MemRead and MemWrite: treated as a load.
    do_access(1'b1, 1'b1, 3'b101, 32'h36, 32'h0, 1, 2, 32'h9876_5432);
    @(negedge clk);
    // Misaligned word: trap or truncated access.
    do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 32'h1357_9BDF);
    @(negedge clk);

    // req_valid with neither read nor write is ignored.
    req_valid = 1'b1; Funct3 = 3'b010; ALUResult = 32'h80;
    @(negedge clk);
    req_valid = 1'b0;
    check("ign_ready", {31'h0, req_ready}, 32'd1);
    check("ign_mem_req", {31'h0, mem_req}, 32'd0);
    check("ign_stall", {31'h0, Stall}, 32'd0);

    // Reset during WAIT.
    req_valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h300;
    @(negedge clk);
    req_valid = 1'b0; MemRead = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rstw_stall_pre", {31'h0, Stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_ready", {31'h0, req_ready}, 32'd1);
    check("rstw_stall", {31'h0, Stall}, 32'd0);
    check("rstw_mem_req", {31'h0, mem_req}, 32'd0);
    check("rstw_rdata", ReadData, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      check("rstw_noresp", {31'h0, resp_valid}, 32'd0);
    end

    // Randomized accesses.
    for (int n = 0; n < 40; n++) begin
      int kind = int'($urandom_range(0, 2));
      bit rd = (kind != 1);
      bit wr = (kind != 0);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      if (!rd && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 & 3'b011;
      do_access(rd, wr, f3, $urandom, $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), $urandom);
      @(negedge clk);
    end
    check("end_idle", {31'h0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
